// File: rtl/rans_pkg.sv
// Shared constants, decoder state encoding and the byte shift used when
// refilling the rANS state.
package rans_pkg;

    localparam int STATE_WIDTH = 32;
    localparam int BYTE_WIDTH  = 8;
    localparam logic [STATE_WIDTH-1:0] RANS_L = 32'h0080_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOOKUP,
        ST_UPDATE,
        ST_RENORM,
        ST_FINISH
    } dec_state_e;

    function automatic logic [STATE_WIDTH-1:0] shift_in_byte(
        input logic [STATE_WIDTH-1:0] x,
        input logic [BYTE_WIDTH-1:0]  b
    );
        return {x[STATE_WIDTH-BYTE_WIDTH-1:0], b};
    endfunction

endpackage

// File: rtl/rans_dec_table.sv
// Decoder tables: per-symbol {freq,cum} store plus the slot->symbol map,
// which is filled one slot per cycle after each accepted table write.
module rans_dec_table
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_i,
    input  logic [SYMBOL_WIDTH-1:0] wr_addr_i,
    input  logic [RESOLUTION-1:0]   wr_freq_i,
    input  logic [RESOLUTION-1:0]   wr_cum_i,
    output logic                    fill_busy_o,
    input  logic                    rd_en_i,
    input  logic [RESOLUTION-1:0]   rd_slot_i,
    output logic [SYMBOL_WIDTH-1:0] rd_sym_o,
    output logic [RESOLUTION-1:0]   rd_freq_o,
    output logic [RESOLUTION-1:0]   rd_cum_o
);

    logic [SYMBOL_WIDTH-1:0] slot_mem [2**RESOLUTION];
    logic [RESOLUTION-1:0]   freq_mem [2**SYMBOL_WIDTH];
    logic [RESOLUTION-1:0]   cum_mem  [2**SYMBOL_WIDTH];
    logic [SYMBOL_WIDTH-1:0] rd_sym_q;

    logic [RESOLUTION-1:0]   fill_cnt_q, fill_cnt_d;
    logic [RESOLUTION-1:0]   fill_addr_q, fill_addr_d;
    logic [SYMBOL_WIDTH-1:0] fill_sym_q, fill_sym_d;

    assign fill_busy_o = (fill_cnt_q != '0);

    // Slot address is R bits wide, so cum+freq past the top wraps to slot 0.
    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        fill_addr_d = fill_addr_q;
        fill_sym_d  = fill_sym_q;
        if (wr_i) begin
            fill_cnt_d  = wr_freq_i;
            fill_addr_d = wr_cum_i;
            fill_sym_d  = wr_addr_i;
        end else if (fill_busy_o) begin
            fill_cnt_d  = fill_cnt_q - 1'b1;
            fill_addr_d = fill_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_cnt_q  <= '0;
            fill_addr_q <= '0;
            fill_sym_q  <= '0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            fill_addr_q <= fill_addr_d;
            fill_sym_q  <= fill_sym_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            freq_mem[wr_addr_i] <= wr_freq_i;
            cum_mem[wr_addr_i]  <= wr_cum_i;
        end
        if (fill_busy_o) begin
            slot_mem[fill_addr_q] <= fill_sym_q;
        end
        if (rd_en_i) begin
            rd_sym_q <= slot_mem[rd_slot_i];
        end
    end

    // The small per-symbol table is read straight off the registered slot
    // lookup so freq/cum arrive in the same cycle as the symbol.
    assign rd_sym_o  = rd_sym_q;
    assign rd_freq_o = freq_mem[rd_sym_q];
    assign rd_cum_o  = cum_mem[rd_sym_q];

endmodule

// File: rtl/rans_decoder.sv
// Byte-wise rANS decoder: loads the 32-bit final state, then alternates
// slot lookup, state update and byte renormalisation once per symbol.
module rans_decoder
    import rans_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0] freq_addr_i,
    input  logic [RESOLUTION-1:0]   freq_i,
    input  logic [RESOLUTION-1:0]   cum_freq_i,
    output logic                    tbl_busy_o,
    input  logic                    start_i,
    input  logic [COUNT_WIDTH-1:0]  nsym_i,
    input  logic                    restart_i,
    input  logic                    byte_valid_i,
    input  logic [BYTE_WIDTH-1:0]   byte_i,
    output logic                    byte_ready_o,
    output logic                    symb_valid_o,
    output logic [SYMBOL_WIDTH-1:0] symb_o,
    output logic                    symb_last_o,
    input  logic                    symb_ready_i,
    output logic                    done_o,
    output logic                    err_o
);

    dec_state_e                 state_q, state_d;
    logic [STATE_WIDTH-1:0]     x_q, x_d;
    logic [COUNT_WIDTH-1:0]     rem_q, rem_d;
    logic [1:0]                 bcnt_q, bcnt_d;
    logic                       symb_valid_q, symb_valid_d;
    logic [SYMBOL_WIDTH-1:0]    symb_q, symb_d;
    logic                       symb_last_q, symb_last_d;
    logic                       err_q, err_d;

    logic                       fill_busy;
    logic                       tbl_wr;
    logic                       start_ok;
    logic                       byte_acc;
    logic                       out_free;
    logic                       x_low;
    logic [SYMBOL_WIDTH-1:0]    rd_sym;
    logic [RESOLUTION-1:0]      rd_freq;
    logic [RESOLUTION-1:0]      rd_cum;
    logic [STATE_WIDTH-1:0]     x_upd;

    assign tbl_busy_o   = fill_busy || (state_q != ST_IDLE);
    assign tbl_wr       = freq_wr_i && !tbl_busy_o;
    assign start_ok     = (state_q == ST_IDLE) && start_i && !fill_busy
                          && !freq_wr_i && !restart_i;
    assign x_low        = (x_q < RANS_L);
    assign byte_ready_o = (state_q == ST_LOAD) || ((state_q == ST_RENORM) && x_low);
    assign byte_acc     = byte_valid_i && byte_ready_o;
    assign out_free     = !symb_valid_q || symb_ready_i;

    // freq*(x>>R) + slot - cum; encoder invariants keep this inside 32 bits.
    assign x_upd = STATE_WIDTH'(rd_freq) * (x_q >> RESOLUTION)
                 + STATE_WIDTH'(x_q[RESOLUTION-1:0])
                 - STATE_WIDTH'(rd_cum);

    rans_dec_table #(
        .RESOLUTION   (RESOLUTION),
        .SYMBOL_WIDTH (SYMBOL_WIDTH)
    ) u_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wr_i        (tbl_wr),
        .wr_addr_i   (freq_addr_i),
        .wr_freq_i   (freq_i),
        .wr_cum_i    (cum_freq_i),
        .fill_busy_o (fill_busy),
        .rd_en_i     (state_q == ST_LOOKUP),
        .rd_slot_i   (x_q[RESOLUTION-1:0]),
        .rd_sym_o    (rd_sym),
        .rd_freq_o   (rd_freq),
        .rd_cum_o    (rd_cum)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        rem_d        = rem_q;
        bcnt_d       = bcnt_q;
        symb_valid_d = symb_valid_q;
        symb_d       = symb_q;
        symb_last_d  = symb_last_q;
        err_d        = err_q;

        if (symb_valid_q && symb_ready_i) begin
            symb_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    rem_d   = nsym_i;
                    x_d     = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (byte_acc) begin
                    x_d    = shift_in_byte(x_q, byte_i);
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = (rem_q != '0) ? ST_LOOKUP : ST_FINISH;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                x_d          = x_upd;
                symb_d       = rd_sym;
                symb_valid_d = 1'b1;
                symb_last_d  = (rem_q == COUNT_WIDTH'(1));
                rem_d        = rem_q - 1'b1;
                state_d      = ST_RENORM;
            end
            ST_RENORM: begin
                if (x_low) begin
                    if (byte_acc) begin
                        x_d = shift_in_byte(x_q, byte_i);
                    end
                end else if (out_free) begin
                    state_d = (rem_q == '0) ? ST_FINISH : ST_LOOKUP;
                end
            end
            ST_FINISH: begin
                if (!symb_valid_q) begin
                    err_d   = (x_q != RANS_L);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (restart_i) begin
            state_d      = ST_IDLE;
            symb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            rem_q        <= '0;
            bcnt_q       <= '0;
            symb_valid_q <= 1'b0;
            symb_q       <= '0;
            symb_last_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            rem_q        <= rem_d;
            bcnt_q       <= bcnt_d;
            symb_valid_q <= symb_valid_d;
            symb_q       <= symb_d;
            symb_last_q  <= symb_last_d;
            err_q        <= err_d;
        end
    end

    assign symb_valid_o = symb_valid_q;
    assign symb_o       = symb_q;
    assign symb_last_o  = symb_last_q;
    assign err_o        = err_q;
    assign done_o       = (state_q == ST_FINISH) && !symb_valid_q;

endmodule

// File: tb/tb_rans_decoder.sv
// Directed bench for rans_decoder: table fill timing, single/multi symbol
// decodes, renormalisation, error flag, output backpressure and restart.
module tb_rans_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freq_wr_i = 1'b0;
    logic [7:0]  freq_addr_i = '0;
    logic [9:0]  freq_i = '0;
    logic [9:0]  cum_freq_i = '0;
    logic        tbl_busy_o;
    logic        start_i = 1'b0;
    logic [15:0] nsym_i = '0;
    logic        restart_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_ready_o;
    logic        symb_valid_o;
    logic [7:0]  symb_o;
    logic        symb_last_o;
    logic        symb_ready_i = 1'b1;
    logic        done_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] in_bytes [8];
    int         r_nsym, r_bytes, r_stall_bytes, busy_cnt;
    logic [7:0] r_sym [4];
    logic       r_last [4];
    logic       r_done, r_err, r_timeout, r_stall_bad;

    always #5 clk = ~clk;

    rans_decoder dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .freq_wr_i    (freq_wr_i),
        .freq_addr_i  (freq_addr_i),
        .freq_i       (freq_i),
        .cum_freq_i   (cum_freq_i),
        .tbl_busy_o   (tbl_busy_o),
        .start_i      (start_i),
        .nsym_i       (nsym_i),
        .restart_i    (restart_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .symb_valid_o (symb_valid_o),
        .symb_o       (symb_o),
        .symb_last_o  (symb_last_o),
        .symb_ready_i (symb_ready_i),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    task automatic load_bytes(input logic [7:0] b0, b1, b2, b3, b4, b5);
        in_bytes[0] = b0; in_bytes[1] = b1; in_bytes[2] = b2;
        in_bytes[3] = b3; in_bytes[4] = b4; in_bytes[5] = b5;
        in_bytes[6] = 8'h00; in_bytes[7] = 8'h00;
    endtask

    // Writes one table entry and measures how many cycles tbl_busy_o stays high.
    task automatic tbl_write(input logic [7:0] a, input logic [9:0] f,
                             input logic [9:0] c, input logic with_start);
        @(posedge clk); #1;
        freq_wr_i = 1'b1; freq_addr_i = a; freq_i = f; cum_freq_i = c;
        start_i = with_start; nsym_i = 16'd1;
        @(posedge clk); #1;
        freq_wr_i = 1'b0; start_i = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tbl_busy_o) busy_cnt++;
            else break;
        end
        $display("table write sym=%h f=%0d c=%0d busy=%0d", a, f, c, busy_cnt);
    endtask

    // Runs one decode: offers nbytes bytes, holds symb_ready_i low for 'stall'
    // cycles of a presented symbol, and records what came out.
    task automatic run_dec(input int nsym, input int nbytes, input int stall,
                           input int max_cycles);
        int idx = 0;
        int cyc = 0;
        int stall_left = stall;
        logic acc;
        logic [7:0] held = '0;
        r_nsym = 0; r_bytes = 0; r_stall_bytes = 0;
        r_done = 1'b0; r_stall_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin r_sym[i] = '0; r_last[i] = 1'b0; end
        @(posedge clk); #1;
        start_i = 1'b1; nsym_i = 16'(nsym);
        @(posedge clk); #1;
        start_i = 1'b0;
        symb_ready_i = (stall == 0);
        byte_valid_i = (idx < nbytes);
        byte_i = in_bytes[idx];
        while (!r_done && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            acc = byte_valid_i && byte_ready_o;
            if (acc) r_bytes++;
            if (symb_valid_o && symb_ready_i) begin
                if (r_nsym < 4) begin
                    r_sym[r_nsym] = symb_o;
                    r_last[r_nsym] = symb_last_o;
                end
                r_nsym++;
            end
            if (symb_valid_o && !symb_ready_i && stall_left > 0) begin
                if (stall_left == stall) held = symb_o;
                else if (symb_o !== held) r_stall_bad = 1'b1;
                if (acc) r_stall_bytes++;
                if (done_o) r_stall_bad = 1'b1;
                stall_left--;
            end
            if (done_o) r_done = 1'b1;
            @(posedge clk); #1;
            if (acc) idx++;
            byte_valid_i = (idx < nbytes);
            byte_i = (idx < 8) ? in_bytes[idx] : 8'h00;
            symb_ready_i = (stall_left == 0);
        end
        r_err = err_o;
        r_timeout = !r_done;
        byte_valid_i = 1'b0;
        symb_ready_i = 1'b1;
        $display("decode nsym=%0d syms=%0d s0=%h bytes=%0d done=%0b err=%0b",
                 nsym, r_nsym, r_sym[0], r_bytes, r_done, r_err);
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if (tbl_busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", tbl_busy_o); end
        n_cmp++; if (byte_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_bready got %b want 0", byte_ready_o); end
        n_cmp++; if (symb_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_svalid got %b want 0", symb_valid_o); end
        n_cmp++; if ({symb_o, symb_last_o} !== 9'h0) begin n_bad++; $display("FAIL rst_symb got %h want 0", {symb_o, symb_last_o}); end
        n_cmp++; if ({done_o, err_o} !== 2'b00) begin n_bad++; $display("FAIL rst_done_err got %b want 00", {done_o, err_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({tbl_busy_o, byte_ready_o, symb_valid_o} !== 3'b000) begin n_bad++; $display("FAIL post_rst got %b want 000", {tbl_busy_o, byte_ready_o, symb_valid_o}); end
        $display("reset checked");
    endtask

    task automatic test_table_ab;
        tbl_write(8'h41, 10'd512, 10'd0, 1'b0);
        n_cmp++; if (busy_cnt !== 512) begin n_bad++; $display("FAIL busy_A got %0d want 512", busy_cnt); end
        tbl_write(8'h42, 10'd512, 10'd512, 1'b0);
        n_cmp++; if (busy_cnt !== 512) begin n_bad++; $display("FAIL busy_B got %0d want 512", busy_cnt); end
    endtask

    task automatic test_write_beats_start;
        tbl_write(8'h41, 10'd512, 10'd0, 1'b1);
        n_cmp++; if (busy_cnt !== 512) begin n_bad++; $display("FAIL wr_win_busy got %0d want 512", busy_cnt); end
        n_cmp++; if (byte_ready_o !== 1'b0) begin n_bad++; $display("FAIL wr_win_idle got %b want 0", byte_ready_o); end
    endtask

    task automatic test_single;
        load_bytes(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_dec(1, 4, 0, 100);
        n_cmp++; if (r_timeout !== 1'b0) begin n_bad++; $display("FAIL s1_timeout got %b want 0", r_timeout); end
        n_cmp++; if (r_nsym !== 1 || r_sym[0] !== 8'h41) begin n_bad++; $display("FAIL s1_sym got %0d/%h want 1/41", r_nsym, r_sym[0]); end
        n_cmp++; if (r_last[0] !== 1'b1) begin n_bad++; $display("FAIL s1_last got %b want 1", r_last[0]); end
        n_cmp++; if (r_err !== 1'b0 || r_bytes !== 4) begin n_bad++; $display("FAIL s1_err_bytes got %b/%0d want 0/4", r_err, r_bytes); end
        load_bytes(8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00);
        run_dec(1, 4, 0, 100);
        n_cmp++; if (r_nsym !== 1 || r_sym[0] !== 8'h42) begin n_bad++; $display("FAIL s2_sym got %0d/%h want 1/42", r_nsym, r_sym[0]); end
        n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b0) begin n_bad++; $display("FAIL s2_done_err got %b/%b want 1/0", r_done, r_err); end
    endtask

    task automatic test_err;
        load_bytes(8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00);
        run_dec(1, 4, 0, 100);
        n_cmp++; if (r_nsym !== 1 || r_sym[0] !== 8'h41) begin n_bad++; $display("FAIL e_sym got %0d/%h want 1/41", r_nsym, r_sym[0]); end
        n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b1) begin n_bad++; $display("FAIL e_done_err got %b/%b want 1/1", r_done, r_err); end
    endtask

    task automatic test_zero_symbols;
        load_bytes(8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
        run_dec(0, 4, 0, 100);
        n_cmp++; if (r_nsym !== 0 || r_done !== 1'b1) begin n_bad++; $display("FAIL z_run got %0d/%b want 0/1", r_nsym, r_done); end
        n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL z_err got %b want 0", r_err); end
    endtask

    task automatic test_backpressure;
        // Second symbol: x=0x400000 needs one renorm byte; final x != RANS_L.
        load_bytes(8'h01, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h00);
        run_dec(2, 5, 10, 200);
        n_cmp++; if (r_stall_bad !== 1'b0) begin n_bad++; $display("FAIL bp_stable got %b want 0", r_stall_bad); end
        n_cmp++; if (r_stall_bytes !== 0) begin n_bad++; $display("FAIL bp_bytes got %0d want 0", r_stall_bytes); end
        n_cmp++; if (r_nsym !== 2 || r_sym[0] !== 8'h41 || r_sym[1] !== 8'h41) begin n_bad++; $display("FAIL bp_syms got %0d/%h/%h want 2/41/41", r_nsym, r_sym[0], r_sym[1]); end
        n_cmp++; if ({r_last[0], r_last[1]} !== 2'b01) begin n_bad++; $display("FAIL bp_last got %b want 01", {r_last[0], r_last[1]}); end
        n_cmp++; if (r_bytes !== 5 || r_err !== 1'b1) begin n_bad++; $display("FAIL bp_bytes_err got %0d/%b want 5/1", r_bytes, r_err); end
    endtask

    task automatic test_renorm;
        tbl_write(8'h43, 10'd1, 10'd0, 1'b0);
        n_cmp++; if (busy_cnt !== 1) begin n_bad++; $display("FAIL busy_C got %0d want 1", busy_cnt); end
        tbl_write(8'h44, 10'd1023, 10'd1, 1'b0);
        n_cmp++; if (busy_cnt !== 1023) begin n_bad++; $display("FAIL busy_D got %0d want 1023", busy_cnt); end
        load_bytes(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        run_dec(1, 6, 0, 100);
        n_cmp++; if (r_nsym !== 1 || r_sym[0] !== 8'h43) begin n_bad++; $display("FAIL rn_sym got %0d/%h want 1/43", r_nsym, r_sym[0]); end
        n_cmp++; if (r_bytes !== 5) begin n_bad++; $display("FAIL rn_bytes got %0d want 5", r_bytes); end
        n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b0) begin n_bad++; $display("FAIL rn_done_err got %b/%b want 1/0", r_done, r_err); end
    endtask

    task automatic test_restart;
        // Starve the renorm byte so the decoder parks in RENORM.
        load_bytes(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_dec(1, 4, 0, 20);
        n_cmp++; if (r_timeout !== 1'b1 || r_nsym !== 1) begin n_bad++; $display("FAIL rs_park got %b/%0d want 1/1", r_timeout, r_nsym); end
        n_cmp++; if ({tbl_busy_o, byte_ready_o} !== 2'b11) begin n_bad++; $display("FAIL rs_renorm got %b want 11", {tbl_busy_o, byte_ready_o}); end
        restart_i = 1'b1;
        @(posedge clk); #1;
        restart_i = 1'b0;
        n_cmp++; if ({tbl_busy_o, byte_ready_o, symb_valid_o, done_o} !== 4'b0000) begin n_bad++; $display("FAIL rs_idle got %b want 0000", {tbl_busy_o, byte_ready_o, symb_valid_o, done_o}); end
        load_bytes(8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        run_dec(1, 6, 0, 100);
        n_cmp++; if (r_nsym !== 1 || r_sym[0] !== 8'h43 || r_bytes !== 5) begin n_bad++; $display("FAIL rs_rerun got %0d/%h/%0d want 1/43/5", r_nsym, r_sym[0], r_bytes); end
        n_cmp++; if (r_done !== 1'b1 || r_err !== 1'b0) begin n_bad++; $display("FAIL rs_done_err got %b/%b want 1/0", r_done, r_err); end
    endtask

    initial begin
        load_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_table_ab();
        test_write_beats_start();
        test_single();
        test_err();
        test_zero_symbols();
        test_backpressure();
        test_renorm();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
